mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single RAM port between the instruction cache (read-only) and the data cache (read/write, two-word block fills and writebacks).
- Arbitrates word requests, holds a grant across a dcache two-word burst, and bounds icache starvation.
- Sits between both caches and RAM inside the memory control block. Data paths are combinational pass-through; grants are registered.

Parameters:
- MAX_D_STREAK, 4, consecutive dcache grants allowed while an icache request is pending before icache is forced in (range 1..15).
- ADDR_W, 32, address and data width.

Ports:
- CLK  in  1  clock, single domain.
- RST  in  1  synchronous active-high reset.
- iREN  in  1  icache read request.
- iaddr  in  ADDR_W  icache word address.
- iload  out  ADDR_W  icache read data.
- iwait  out  1  icache stall.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request.
- daddr  in  ADDR_W  dcache word address.
- dstore  in  ADDR_W  dcache write data.
- dburst  in  1  sampled at dcache word completion; 1 keeps the grant for the next dcache word.
- dload  out  ADDR_W  dcache read data.
- dwait  out  1  dcache stall.
- ramREN  out  1  RAM read.
- ramWEN  out  1  RAM write.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  ADDR_W  RAM write data.
- ramload  in  ADDR_W  RAM read data.
- ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.

Behaviour:
- Registered state: IDLE, IGNT, DGNT. Also dstreak (4-bit counter) and dlock (1 bit).
- Reset: state=IDLE, dstreak=0, dlock=0. Reset taken mid-access: ram outputs drop on the next cycle, with no completion signalled.
- IDLE:
  - ramREN=ramWEN=0, ramaddr=0, ramstore=0.
  - Arbitration moves to the next state at the clock edge.
  - Only dREN|dWEN pending -> DGNT.
  - Only iREN pending -> IGNT.
  - Both pending: IGNT if dstreak>=MAX_D_STREAK, else DGNT.
- IGNT: ramREN=1, ramWEN=0, ramaddr=iaddr.
- DGNT:
  - ramaddr=daddr, ramstore=dstore.
  - dWEN=1 gives a write (ramWEN=1, ramREN=0), even if dREN is also set.
  - Otherwise ramREN=dREN.
- Loads: iload=ramload and dload=ramload at all times (combinational).
- Completion is a granted cycle with ramstate==ACCESS:
  - The granted requester's wait is 0 for exactly that cycle.
  - IGNT completion: dstreak<=0, next state IDLE.
  - DGNT completion with dburst=1 and dlock=0: dlock<=1, stay in DGNT, and the second word issues on the next cycle.
  - DGNT completion otherwise: dlock<=0, next state IDLE.
  - Every DGNT completion increments dstreak if iREN is pending, saturating at 15. If iREN is not pending, dstreak<=0.
  - A burst is at most two words. dburst on the second word is ignored.
  - The starvation check applies only in IDLE, so it never breaks a locked burst.
- Waits:
  - iwait = iREN & ~(state==IGNT & ramstate==ACCESS).
  - dwait = (dREN|dWEN) & ~(state==DGNT & ramstate==ACCESS).
  - With no request, wait=0.
- ramstate ERROR while granted: no completion is signalled (wait stays 1), dlock<=0, next state IDLE. The request is re-arbitrated as a fresh request.
- Requester drops its request while granted (no completion yet): next state IDLE, dlock<=0, dstreak unchanged.
- A state change always has a minimum one-cycle IDLE bubble between different grants.
- A requester must hold its address and data stable while wait=1. Changing them mid-grant is undefined.

Test Plan:
- iREN=1, iaddr=0x40, RAM ACCESS after 2 BUSY cycles, ramload=0xDEADBEEF -> ramREN=1 and ramaddr=0x40 from cycle 1. iwait=0 with iload=0xDEADBEEF only in the ACCESS cycle. IDLE next.
- iREN and dREN asserted together at reset release -> DGNT first, iwait=1 throughout. Icache is granted after the dcache word completes plus one IDLE cycle.
- Continuous dREN plus continuous iREN, RAM ACCESS every 2nd cycle, MAX_D_STREAK=4 -> exactly 4 dcache completions, then 1 icache completion, repeating.
- dWEN=1 with dburst=1, daddr=0x100 then 0x104, dstore=0x11/0x22, iREN pending -> two consecutive ram writes with no IDLE between them. ramstore is 0x11 then 0x22. Icache is granted only afterwards.
- ramstate=ERROR during IGNT -> iwait stays 1, state returns to IDLE, and the request reissues next cycle and completes on a later ACCESS.
- RST=1 asserted mid-DGNT write -> ramWEN=0 on the next cycle, dstreak=0, and arbitration resumes from IDLE after RST falls.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single RAM port arbiter between icache and dcache with burst lock and starvation bound
//
// Ports:
//   CLK, RST                      clock and synchronous active-high reset
//   iREN, iaddr, iload, iwait     icache read-only requester
//   dREN, dWEN, daddr, dstore,
//   dburst, dload, dwait          dcache read/write requester (dburst holds the grant for one more word)
//   ramREN, ramWEN, ramaddr,
//   ramstore, ramload, ramstate   shared RAM port (ramstate: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR)
module mem_arbiter #(
    parameter int MAX_D_STREAK = 4,
    parameter int ADDR_W       = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic [ADDR_W-1:0] iload,
    output logic              iwait,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [ADDR_W-1:0] dstore,
    input  logic              dburst,
    output logic [ADDR_W-1:0] dload,
    output logic              dwait,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [ADDR_W-1:0] ramstore,
    input  logic [ADDR_W-1:0] ramload,
    input  logic [1:0]        ramstate
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } state_t;

    localparam logic [1:0] RAM_ACCESS   = 2'd2;
    localparam logic [1:0] RAM_ERROR    = 2'd3;
    localparam logic [3:0] STREAK_LIMIT = 4'(MAX_D_STREAK);

    state_t     state_q, state_d;
    logic [3:0] dstreak_q, dstreak_d;
    logic       dlock_q, dlock_d;

    logic d_req;
    logic ram_access;
    logic ram_error;

    assign d_req      = dREN | dWEN;
    assign ram_access = (ramstate == RAM_ACCESS);
    assign ram_error  = (ramstate == RAM_ERROR);

    // A completion is a granted cycle in which the RAM reports ACCESS.
    assign iwait = iREN  & ~((state_q == IGNT) & ram_access);
    assign dwait = d_req & ~((state_q == DGNT) & ram_access);

    assign iload = ramload;
    assign dload = ramload;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            dstreak_q <= 4'd0;
            dlock_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            dstreak_q <= dstreak_d;
            dlock_q   <= dlock_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        dstreak_d = dstreak_q;
        dlock_d   = dlock_q;
        ramREN    = 1'b0;
        ramWEN    = 1'b0;
        ramaddr   = '0;
        ramstore  = '0;

        unique case (state_q)
            IDLE: begin
                // Starvation bound is only consulted here, so a locked burst is never split.
                if (d_req && iREN) begin
                    state_d = (dstreak_q >= STREAK_LIMIT) ? IGNT : DGNT;
                end else if (d_req) begin
                    state_d = DGNT;
                end else if (iREN) begin
                    state_d = IGNT;
                end
            end

            IGNT: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
                if (!iREN || ram_error) begin
                    state_d = IDLE;
                    dlock_d = 1'b0;
                end else if (ram_access) begin
                    state_d   = IDLE;
                    dstreak_d = 4'd0;
                end
            end

            DGNT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;    // write wins when both are raised
                if (!d_req || ram_error) begin
                    state_d = IDLE;
                    dlock_d = 1'b0;
                end else if (ram_access) begin
                    if (iREN) begin
                        dstreak_d = (dstreak_q == 4'hF) ? 4'hF : dstreak_q + 4'd1;
                    end else begin
                        dstreak_d = 4'd0;
                    end
                    // dlock marks the second word of a burst; dburst on that word is ignored.
                    if (dburst && !dlock_q) begin
                        dlock_d = 1'b1;
                    end else begin
                        dlock_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter: directed scenarios plus randomized model comparison
module tb_mem_arbiter;

    localparam int MAXS = 4;
    localparam int W    = 32;
    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    logic         CLK = 1'b0;
    logic         RST;
    logic         iREN;
    logic [W-1:0] iaddr;
    logic [W-1:0] iload;
    logic         iwait;
    logic         dREN;
    logic         dWEN;
    logic [W-1:0] daddr;
    logic [W-1:0] dstore;
    logic         dburst;
    logic [W-1:0] dload;
    logic         dwait;
    logic         ramREN;
    logic         ramWEN;
    logic [W-1:0] ramaddr;
    logic [W-1:0] ramstore;
    logic [W-1:0] ramload;
    logic [1:0]   ramstate;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    mem_arbiter #(.MAX_D_STREAK(MAXS), .ADDR_W(W)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dburst(dburst),
        .dload(dload), .dwait(dwait),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        iREN = 0; iaddr = '0; dREN = 0; dWEN = 0; daddr = '0; dstore = '0;
        dburst = 0; ramload = '0; ramstate = FREE;
    endtask

    task automatic do_reset();
        idle_inputs();
        RST = 1;
        next_cycle();
        next_cycle();
        RST = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        RST = 1; iREN = 1; dWEN = 1; daddr = 32'h1234; ramstate = ACCESS;
        next_cycle();
        #4;
        checks++; if (ramREN !== 1'b0) begin failures++; $display("FAIL reset_ramREN got=%b want=0", ramREN); end
        checks++; if (ramWEN !== 1'b0) begin failures++; $display("FAIL reset_ramWEN got=%b want=0", ramWEN); end
        checks++; if (ramaddr !== '0) begin failures++; $display("FAIL reset_ramaddr got=%h want=0", ramaddr); end
        checks++; if (ramstore !== '0) begin failures++; $display("FAIL reset_ramstore got=%h want=0", ramstore); end
        checks++; if (iwait !== 1'b1) begin failures++; $display("FAIL reset_iwait_pending got=%b want=1", iwait); end
        checks++; if (dwait !== 1'b1) begin failures++; $display("FAIL reset_dwait_pending got=%b want=1", dwait); end
        iREN = 0; dWEN = 0;
        #1;
        checks++; if (iwait !== 1'b0) begin failures++; $display("FAIL reset_iwait_noreq got=%b want=0", iwait); end
        checks++; if (dwait !== 1'b0) begin failures++; $display("FAIL reset_dwait_noreq got=%b want=0", dwait); end
        next_cycle();
        RST = 0;
    endtask

    task automatic test_icache_read();
        do_reset();
        iREN = 1; iaddr = 32'h40; ramstate = FREE;
        #4;
        checks++; if (ramREN !== 1'b0) begin failures++; $display("FAIL iread_c0_ramREN got=%b want=0", ramREN); end
        checks++; if (iwait !== 1'b1) begin failures++; $display("FAIL iread_c0_iwait got=%b want=1", iwait); end
        next_cycle();
        for (int c = 1; c <= 3; c++) begin
            ramstate = (c < 3) ? BUSY : ACCESS;
            ramload  = (c < 3) ? 32'h12345678 : 32'hDEADBEEF;
            #4;
            checks++; if (ramREN !== 1'b1) begin failures++; $display("FAIL iread_c%0d_ramREN got=%b want=1", c, ramREN); end
            checks++; if (ramaddr !== 32'h40) begin failures++; $display("FAIL iread_c%0d_ramaddr got=%h want=40", c, ramaddr); end
            checks++; if (iwait !== (c < 3)) begin failures++; $display("FAIL iread_c%0d_iwait got=%b want=%b", c, iwait, (c < 3)); end
            if (c == 3) begin
                checks++; if (iload !== 32'hDEADBEEF) begin failures++; $display("FAIL iread_iload got=%h want=deadbeef", iload); end
            end
            next_cycle();
        end
        iREN = 0; ramstate = FREE;
        #4;
        checks++; if (ramREN !== 1'b0) begin failures++; $display("FAIL iread_after_ramREN got=%b want=0", ramREN); end
        next_cycle();
    endtask

    task automatic test_priority();
        idle_inputs();
        RST = 1; iREN = 1; dREN = 1; iaddr = 32'h44; daddr = 32'h88; ramstate = ACCESS;
        next_cycle();
        RST = 0;
        #4;
        checks++; if (ramREN !== 1'b0) begin failures++; $display("FAIL prio_c0_ramREN got=%b want=0", ramREN); end
        checks++; if (iwait !== 1'b1 || dwait !== 1'b1) begin failures++; $display("FAIL prio_c0_waits got=%b%b want=11", iwait, dwait); end
        next_cycle();
        #4;
        checks++; if (ramaddr !== 32'h88 || ramREN !== 1'b1) begin failures++; $display("FAIL prio_c1_dgrant got addr=%h ren=%b want addr=88 ren=1", ramaddr, ramREN); end
        checks++; if (dwait !== 1'b0 || iwait !== 1'b1) begin failures++; $display("FAIL prio_c1_waits got i=%b d=%b want i=1 d=0", iwait, dwait); end
        next_cycle();
        dREN = 0;
        #4;
        checks++; if (ramREN !== 1'b0 || iwait !== 1'b1) begin failures++; $display("FAIL prio_c2_bubble got ren=%b iwait=%b want 0 1", ramREN, iwait); end
        next_cycle();
        #4;
        checks++; if (ramaddr !== 32'h44 || ramREN !== 1'b1 || iwait !== 1'b0) begin failures++; $display("FAIL prio_c3_igrant got addr=%h ren=%b iwait=%b want 44 1 0", ramaddr, ramREN, iwait); end
        next_cycle();
        iREN = 0;
        next_cycle();
    endtask

    task automatic test_starvation();
        int n = 0;
        do_reset();
        iREN = 1; dREN = 1; iaddr = 32'h400; daddr = 32'h800;
        for (int cyc = 0; cyc < 200 && n < 15; cyc++) begin
            ramstate = (cyc % 2 == 1) ? ACCESS : BUSY;
            #4;
            if (iwait === 1'b0 || dwait === 1'b0) begin
                checks++;
                if ((iwait === 1'b0) !== ((n % 5) == 4) || (iwait === dwait)) begin
                    failures++;
                    $display("FAIL starve_order completion=%0d got iwait=%b dwait=%b want icache=%0d", n, iwait, dwait, ((n % 5) == 4));
                end
                n++;
            end
            next_cycle();
        end
        checks++; if (n != 15) begin failures++; $display("FAIL starve_count got=%0d want=15", n); end
        idle_inputs();
        next_cycle();
        next_cycle();
    endtask

    task automatic test_burst();
        do_reset();
        dWEN = 1; dREN = 1; dburst = 1; daddr = 32'h100; dstore = 32'h11;
        iREN = 1; iaddr = 32'h200; ramstate = ACCESS;
        #4;
        checks++; if (ramWEN !== 1'b0 || ramREN !== 1'b0) begin failures++; $display("FAIL burst_c0_idle got wen=%b ren=%b want 0 0", ramWEN, ramREN); end
        next_cycle();
        #4;
        checks++; if (ramWEN !== 1'b1 || ramREN !== 1'b0) begin failures++; $display("FAIL burst_w1_cmd got wen=%b ren=%b want 1 0", ramWEN, ramREN); end
        checks++; if (ramaddr !== 32'h100 || ramstore !== 32'h11) begin failures++; $display("FAIL burst_w1_data got %h/%h want 100/11", ramaddr, ramstore); end
        checks++; if (dwait !== 1'b0 || iwait !== 1'b1) begin failures++; $display("FAIL burst_w1_waits got i=%b d=%b want 1 0", iwait, dwait); end
        next_cycle();
        daddr = 32'h104; dstore = 32'h22; dREN = 0;
        #4;
        checks++; if (ramWEN !== 1'b1 || ramaddr !== 32'h104 || ramstore !== 32'h22) begin failures++; $display("FAIL burst_w2 got wen=%b %h/%h want 1 104/22", ramWEN, ramaddr, ramstore); end
        checks++; if (dwait !== 1'b0) begin failures++; $display("FAIL burst_w2_dwait got=%b want=0", dwait); end
        next_cycle();
        #4;
        checks++; if (ramWEN !== 1'b0 || ramREN !== 1'b0) begin failures++; $display("FAIL burst_no_third got wen=%b ren=%b want 0 0", ramWEN, ramREN); end
        dWEN = 0;
        next_cycle();
        #4;
        checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h200 || iwait !== 1'b0) begin failures++; $display("FAIL burst_then_icache got ren=%b addr=%h iwait=%b want 1 200 0", ramREN, ramaddr, iwait); end
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_error();
        do_reset();
        iREN = 1; iaddr = 32'h80; ramstate = FREE;
        #4;
        checks++; if (ramREN !== 1'b0) begin failures++; $display("FAIL err_c0_ramREN got=%b want=0", ramREN); end
        next_cycle();
        ramstate = ERROR;
        #4;
        checks++; if (ramREN !== 1'b1 || iwait !== 1'b1) begin failures++; $display("FAIL err_c1 got ren=%b iwait=%b want 1 1", ramREN, iwait); end
        next_cycle();
        ramstate = ACCESS;
        #4;
        checks++; if (ramREN !== 1'b0 || iwait !== 1'b1) begin failures++; $display("FAIL err_c2_idle got ren=%b iwait=%b want 0 1", ramREN, iwait); end
        next_cycle();
        ramstate = BUSY;
        #4;
        checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h80 || iwait !== 1'b1) begin failures++; $display("FAIL err_c3_reissue got ren=%b addr=%h iwait=%b want 1 80 1", ramREN, ramaddr, iwait); end
        next_cycle();
        ramstate = ACCESS; ramload = 32'hCAFEF00D;
        #4;
        checks++; if (iwait !== 1'b0 || iload !== 32'hCAFEF00D) begin failures++; $display("FAIL err_c4_done got iwait=%b iload=%h want 0 cafef00d", iwait, iload); end
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_reset_mid();
        int n = 0;
        do_reset();
        iREN = 1; dWEN = 1; daddr = 32'h300; dstore = 32'h55; iaddr = 32'h600; ramstate = ACCESS;
        for (int cyc = 0; cyc < 50 && n < 4; cyc++) begin
            #4;
            if (dwait === 1'b0) n++;
            next_cycle();
        end
        checks++; if (n != 4) begin failures++; $display("FAIL rmid_streak_build got=%0d want=4", n); end
        iREN = 0; ramstate = BUSY;
        #4;
        checks++; if (ramWEN !== 1'b0) begin failures++; $display("FAIL rmid_idle got wen=%b want 0", ramWEN); end
        next_cycle();
        iREN = 1; RST = 1;
        #4;
        checks++; if (ramWEN !== 1'b1 || dwait !== 1'b1) begin failures++; $display("FAIL rmid_write got wen=%b dwait=%b want 1 1", ramWEN, dwait); end
        next_cycle();
        RST = 0;
        #4;
        checks++; if (ramWEN !== 1'b0 || dwait !== 1'b1) begin failures++; $display("FAIL rmid_dropped got wen=%b dwait=%b want 0 1", ramWEN, dwait); end
        next_cycle();
        #4;
        checks++; if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h300 || iwait !== 1'b1) begin failures++; $display("FAIL rmid_streak_cleared got wen=%b ren=%b addr=%h iwait=%b want 1 0 300 1", ramWEN, ramREN, ramaddr, iwait); end
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    // Reference: owner 0 none, 1 icache, 2 dcache; second marks a burst's second word.
    task automatic test_random();
        int m_owner, m_streak, r;
        bit m_second, acc, err, dreq, i_cpl, d_cpl;
        logic e_ren, e_wen, e_iwait, e_dwait;
        logic [W-1:0] e_addr;
        do_reset();
        m_owner = 0; m_streak = 0; m_second = 0;
        i_cpl = 0; d_cpl = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (i_cpl) begin
                iREN = 1'($urandom_range(0, 1)); iaddr = $urandom;
            end else if (!iREN) begin
                if ($urandom_range(0, 2) == 0) begin iREN = 1; iaddr = $urandom; end
            end else if ($urandom_range(0, 40) == 0) begin
                iREN = 0;
            end
            if (d_cpl) begin
                if ($urandom_range(0, 1) == 0) begin dREN = 0; dWEN = 0; end
                daddr = $urandom; dstore = $urandom;
            end else if (!dREN && !dWEN) begin
                if ($urandom_range(0, 2) == 0) begin
                    r = int'($urandom_range(0, 2));
                    dREN = (r != 1); dWEN = (r != 0);
                    daddr = $urandom; dstore = $urandom;
                end
            end else if ($urandom_range(0, 40) == 0) begin
                dREN = 0; dWEN = 0;
            end
            dburst = 1'($urandom_range(0, 1));
            r = int'($urandom_range(0, 9));
            ramstate = (r < 4) ? ACCESS : (r < 7) ? BUSY : (r < 9) ? FREE : ERROR;
            ramload = $urandom;
            RST = ($urandom_range(0, 99) == 0);
            if (RST) ramstate = BUSY;
            #4;
            acc  = (ramstate == ACCESS);
            err  = (ramstate == ERROR);
            dreq = dREN | dWEN;
            e_ren = 0; e_wen = 0; e_addr = '0;
            if (m_owner == 1) begin e_ren = 1; e_addr = iaddr; end
            if (m_owner == 2) begin e_addr = daddr; e_wen = dWEN; e_ren = dREN && !dWEN; end
            e_iwait = iREN && !(m_owner == 1 && acc);
            e_dwait = dreq && !(m_owner == 2 && acc);
            checks++; if (ramREN !== e_ren) begin failures++; $display("FAIL rand_ramREN cyc=%0d got=%b want=%b", cyc, ramREN, e_ren); end
            checks++; if (ramWEN !== e_wen) begin failures++; $display("FAIL rand_ramWEN cyc=%0d got=%b want=%b", cyc, ramWEN, e_wen); end
            checks++; if (ramaddr !== e_addr) begin failures++; $display("FAIL rand_ramaddr cyc=%0d got=%h want=%h", cyc, ramaddr, e_addr); end
            checks++; if (iwait !== e_iwait) begin failures++; $display("FAIL rand_iwait cyc=%0d got=%b want=%b", cyc, iwait, e_iwait); end
            checks++; if (dwait !== e_dwait) begin failures++; $display("FAIL rand_dwait cyc=%0d got=%b want=%b", cyc, dwait, e_dwait); end
            checks++; if (iload !== ramload || dload !== ramload) begin failures++; $display("FAIL rand_loads cyc=%0d got=%h/%h want=%h", cyc, iload, dload, ramload); end
            if (m_owner == 2) begin
                checks++; if (ramstore !== dstore) begin failures++; $display("FAIL rand_ramstore cyc=%0d got=%h want=%h", cyc, ramstore, dstore); end
            end
            i_cpl = iREN && !e_iwait;
            d_cpl = dreq && !e_dwait;
            if (RST) begin
                m_owner = 0; m_streak = 0; m_second = 0;
            end else if (m_owner == 0) begin
                if (dreq && iREN) m_owner = (m_streak >= MAXS) ? 1 : 2;
                else if (dreq)    m_owner = 2;
                else if (iREN)    m_owner = 1;
            end else if (m_owner == 1) begin
                if (!iREN || err) m_owner = 0;
                else if (acc) begin m_streak = 0; m_owner = 0; end
            end else begin
                if (!dreq || err) begin
                    m_owner = 0; m_second = 0;
                end else if (acc) begin
                    m_streak = iREN ? ((m_streak < 15) ? m_streak + 1 : 15) : 0;
                    if (dburst && !m_second) m_second = 1;
                    else begin m_second = 0; m_owner = 0; end
                end
            end
            next_cycle();
        end
        RST = 0;
        idle_inputs();
        next_cycle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1;
        idle_inputs();
        test_reset();
        test_icache_read();
        test_priority();
        test_starvation();
        test_burst();
        test_error();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
